// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the
// bit positions of the {N,Z,C,V} flag vector.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLTU = 3'b110,
    OP_MUL  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU slice: every opcode except the iterative multiply,
// producing the result and its {N,Z,C,V} flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  opcode_e      op,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  logic         w_sub;
  logic [N-1:0] w_b_eff;
  logic [N:0]   w_sum;
  logic         w_carry;
  logic         w_ovf;
  logic         w_use_adder;

  // Everything but ADD that touches the adder is a subtraction/compare.
  assign w_sub   = (op != OP_ADD);
  assign w_b_eff = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};
  assign w_carry = w_sum[N];
  assign w_ovf   = (a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != a[N-1]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    result      = '0;
    w_use_adder = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        result      = w_sum[N-1:0];
        w_use_adder = 1'b1;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: begin
        result      = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf};
        w_use_adder = 1'b1;
      end
      OP_SLTU: begin
        result      = {{(N-1){1'b0}}, ~w_carry};
        w_use_adder = 1'b1;
      end
      default: result = '0;
    endcase

    flags         = '0;
    flags[FLAG_N] = result[N-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = w_use_adder & w_carry;
    flags[FLAG_V] = w_use_adder & w_ovf;
  end

endmodule

// File: rtl/alu_pipe_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops via alu_core,
// MUL as an N-step shift-add loop, registered result and NZCV flags.
module alu_pipe_mc
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ctrl,
  input  logic         flags_we,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplier;
  logic [N-1:0]  r_acc;
  logic          r_fwe;
  logic [N-1:0]  r_result;
  logic [3:0]    r_flags;

  state_e        w_state_next;
  opcode_e       w_op;
  logic          w_accept;
  logic          w_is_mul;
  logic          w_start_mul;
  logic          w_mul_done;
  logic [N-1:0]  w_acc_next;
  logic [3:0]    w_mul_flags;
  logic [N-1:0]  w_core_result;
  logic [3:0]    w_core_flags;

  assign w_op        = opcode_e'(ctrl);
  assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (w_op == OP_MUL);
  assign w_start_mul = w_accept && w_is_mul && MUL_EN;
  assign w_mul_done  = (r_state == ST_MUL) && (r_cnt == CW'(N - 1));

  // One multiplier bit per cycle: add the shifted multiplicand when set.
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_N] = w_acc_next[N-1];
    w_mul_flags[FLAG_Z] = (w_acc_next == '0);
  end

  alu_core #(.N(N)) u_core (
    .a      (a),
    .b      (b),
    .op     (w_op),
    .result (w_core_result),
    .flags  (w_core_flags)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_start_mul ? ST_MUL : ST_OUT;
      ST_MUL:  if (w_mul_done) w_state_next = ST_OUT;
      ST_OUT: begin
        if (w_accept)       w_state_next = w_start_mul ? ST_MUL : ST_OUT;
        else if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_fwe    <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_mul) begin
        r_mcand  <= a;
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_fwe    <= flags_we;
      end else if (w_accept) begin
        // An unimplemented MUL lands here with a zero result and no flag write.
        r_result <= w_core_result;
        if (flags_we && !w_is_mul) r_flags <= w_core_flags;
      end else if (r_state == ST_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_done) begin
          r_result <= w_acc_next;
          r_cnt    <= '0;
          if (r_fwe) r_flags <= w_mul_flags;
        end
      end
    end
  end

  assign out_valid = (r_state == ST_OUT);
  assign busy      = (r_state == ST_MUL);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: doc/alu_pipe_mc.md
ALU_PIPE_MC -- requirements
Module: alu_pipe_mc

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath width in bits (N >= 4).
REQ-002 SHALL have parameter MUL_EN, default 1, meaning MUL opcode implemented (0: MUL treated as illegal).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-007 SHALL have port a, b  input  N each  operands.
REQ-008 SHALL have port ctrl  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU, 111 MUL.
REQ-009 SHALL have port flags_we  input  1  update flag register on completion.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  N  registered result.
REQ-013 SHALL have port flags  output  4  registered {N,Z,C,V}.
REQ-014 SHALL have port busy  output  1  high while in MUL state.

Function
REQ-015 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b, ctrl, flags_we captured at that edge.
REQ-016 FSM states SHALL be IDLE, MUL, OUT; in_ready = (IDLE) || (OUT && out_ready).
REQ-017 Non-MUL ops SHALL load result at the accept edge and enter OUT; out_valid high from the next cycle (latency 1).
REQ-018 MUL SHALL be iterative shift-add, one multiplier bit per cycle, N cycles in MUL; result = low N bits of a*b (unsigned); out_valid high N cycles after accept.
REQ-019 OUT SHALL hold result, flags, out_valid stable until out_ready; on out_ready with no accept go IDLE; with simultaneous accept follow REQ-017/018 (back-to-back, no bubble for non-MUL).
REQ-020 ADD/SUB SHALL compute a + (b or ~b) + sub in N+1 bits; C = carry out (SUB: C=1 means no borrow); V = signed overflow.
REQ-021 SLT SHALL yield 1 iff a < b signed (sum MSB XOR V); SLTU SHALL yield 1 iff a < b unsigned (~C of subtraction); result zero-extended to N.
REQ-022 Flags N = result[N-1], Z = (result == 0) for all ops; C,V from adder for ADD/SUB/SLT/SLTU; C=V=0 for AND/OR/XOR/MUL.
REQ-023 Flag register SHALL update only at the edge result is loaded and only if captured flags_we=1; otherwise retain value.
REQ-024 In_valid during MUL SHALL be ignored (in_ready=0); a/b/ctrl changes after accept SHALL not affect the pending op.
REQ-025 With MUL_EN=0, opcode 111 SHALL complete in 1 cycle with result 0, flags unchanged regardless of flags_we.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, out_valid 0, result 0, flags 0000, busy 0, iteration counter 0.
REQ-027 Reset mid-MUL or in OUT SHALL discard the pending op; in_ready = 1 in the first cycle after release.

Structure
REQ-028 Package alu_pkg SHALL hold opcode enum, FSM state enum and flag bit index constants.
REQ-029 Combinational sub-module alu_core (parametrised N) SHALL compute non-MUL result and NZCV; multiplier iteration stays in alu_pipe_mc.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001, flags_we=1 -> next cycle result 0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-031 SUB 5 - 5 -> result 0, flags 0110 (Z=1, C=1); SUB 0 - 1 -> 0xFFFFFFFF, flags 1000.
REQ-032 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-033 MUL 0x00012345 * 0x00000010 -> 0x00123450 exactly 32 cycles after accept, busy=1 and in_ready=0 throughout; 0x00010000*0x00010000 -> 0, Z=1.
REQ-034 out_ready=0 for 5 cycles after ADD -> result/flags/out_valid stable, new in_valid not accepted; then out_ready=1 with new ADD -> both handled, no bubble.
REQ-035 reset_n pulse at MUL cycle 10 -> out_valid 0, flags 0000 immediately; flags_we=0 op afterwards leaves flags 0000.
